leaf_stream_bridge: RTL and testbench
=====================================

# leaf_stream_bridge

Leaf-side bridge between one BFT leaf port and a single HLS ap_vld/ap_ack stream pair. Incoming 49-bit BFT packets go into a receive FIFO and are presented as an output stream. Outbound stream words are packetized toward a runtime-configured destination leaf/port, with the BFT `resend` backpressure honoured. It takes the place of a hand-written leaf wrapper on any of leaves 1–7.

## Interface
Parameters:
- `RX_DEPTH`, 16: receive FIFO depth in words; power of two, 2–256.
- `MY_LEAF`, 3'd1: this leaf's address; copied into the source field of outbound packets.

Ports:
- `clk`  in  1  sole clock.
- `reset`  in  1  synchronous, active-high.
- `din_leaf_bft2interface`  in  49  packet from BFT: [48] valid, [47:45] dst_leaf, [44:41] dst_port, [40:38] src_leaf, [37:32] reserved, [31:0] payload.
- `dout_leaf_interface2bft`  out  49  packet to BFT, same format.
- `resend`  in  1  from BFT; high means the current `dout` packet was not taken.
- `Input_1_V_V`  in  32  outbound stream data.
- `Input_1_V_V_ap_vld`  in  1  outbound data valid.
- `Input_1_V_V_ap_ack`  out  1  outbound word consumed this cycle.
- `Output_1_V_V`  out  32  inbound stream data (FIFO head).
- `Output_1_V_V_ap_vld`  out  1  FIFO not empty.
- `Output_1_V_V_ap_ack`  in  1  consumer pops this cycle.
- `cfg_done`  out  1  destination has been configured.
- `rx_overflow`  out  1  sticky; a data packet was dropped because the FIFO was full.

## Operation
- Receive classification, on any cycle with din[48]=1:
  - dst_port==0 (config): on the next edge, latch dest_leaf=payload[2:0] and dest_port=payload[6:3], and set `cfg_done`. A later config packet overwrites both values, but only while TX is IDLE or UNCFG. If a config packet arrives while TX is in HOLD, the new values are latched when TX returns to IDLE.
  - dst_port==1 (data): payload is written to the RX FIFO. If the FIFO is full and is not popped that same cycle, the packet is dropped and `rx_overflow` is set.
  - Any other port: discarded silently.
- RX FIFO:
  - Circular buffer with a log2(RX_DEPTH)+1-bit occupancy count; pointers wrap modulo RX_DEPTH.
  - A pop occurs when vld&ack.
  - Push and pop in the same cycle: allowed at any occupancy, including full; count is unchanged.
- TX FSM, states UNCFG, IDLE, HOLD:
  - UNCFG: `ap_ack`=0 and dout valid bit=0. Move to IDLE on the edge that sets `cfg_done`.
  - IDLE: `ap_ack`=`ap_vld`. When ap_vld=1, register {1, dest_leaf, dest_port, MY_LEAF, 6'd0, Input_1_V_V} into dout and go to HOLD.
  - HOLD: dout is held bit-stable.
    - resend=1: stay in HOLD.
    - resend=0 and ap_vld=0: packet accepted; clear valid bit; go to IDLE.
    - resend=0 and ap_vld=1: packet accepted; ack=1 and the new word is loaded in the same cycle (back-to-back, one packet per cycle); stay in HOLD.
- `resend` is ignored when the dout valid bit is 0.

## Timing
- Reset values:
  - dout=49'd0; FIFO empty; `Output_1_V_V_ap_vld`=0.
  - `Input_1_V_V_ap_ack`=0; `cfg_done`=0; `rx_overflow`=0.
  - TX FSM in UNCFG; dest registers 0.
  - `Output_1_V_V` is don't-care while vld=0.
- Reset asserted mid-packet: the held dout packet is abandoned, not retransmitted.
- RX latency: din valid at edge N → `Output_1_V_V_ap_vld`=1 after edge N+1 (FIFO was empty).
- TX latency: vld&ack at edge N → packet on dout after edge N, i.e. visible cycle N+1.
- `Input_1_V_V_ap_ack` is combinational from `ap_vld`, `resend` and FSM state. All other outputs are registered.
- Throughput: one RX word per cycle; one TX packet per cycle when resend=0.

## Configuration
- `LEAF_BRIDGE_STATS_EN` defined: adds 16-bit saturating counters `tx_pkt_cnt`, `rx_pkt_cnt` and `rx_drop_cnt` as output ports. Counters are cleared by `reset`.
  - `tx_pkt_cnt` counts packets accepted with resend=0.
  - `rx_pkt_cnt` counts data packets written to the FIFO.
  - `rx_drop_cnt` counts dropped data packets.
- Not defined: counters and ports are absent; all other behaviour is identical.

## Test plan
- Reset, then drive ap_vld=1 with data 0xDEADBEEF and no config → ack stays 0 and dout=0 for 20 cycles; `cfg_done`=0.
- Config packet with dst_port=0 and payload 0x0000002B → `cfg_done`=1. Then send 0x12345678 → dout = {1, 3'd3, 4'd5, MY_LEAF, 6'd0, 0x12345678} one cycle after ack.
- Hold resend=1 for 3 cycles on a valid packet while ap_vld=1 → dout stable, ack=0 for those 3 cycles. Drop resend → ack=1 on that cycle and the next word appears on the following cycle.
- RX_DEPTH=16: inject 17 data packets (payloads 0..16) with Output ack=0 → vld=1, `rx_overflow`=1. Drain yields 0..15 in order; payload 16 is lost.
- FIFO full, then a data packet and a pop in the same cycle → no drop, count stays 16, and the new payload appears last.
- Reset while TX is in HOLD with resend=1 → dout=0 on the next cycle, FSM in UNCFG, `cfg_done`=0.

Source files
------------

// File: rtl/leaf_stream_bridge.sv
`default_nettype none
// ============================================================================
// Module   : leaf_stream_bridge
// Purpose  : Bridges one BFT leaf port to a single HLS ap_vld/ap_ack stream
//            pair. Inbound data packets are queued in a receive FIFO and
//            presented on Output_1_V_V. Outbound stream words are packetized
//            toward a runtime-configured destination leaf/port, honouring the
//            BFT resend backpressure.
// Ports    : clk, reset                 - clock, synchronous active-high reset
//            din_leaf_bft2interface     - 49-bit packet from the BFT
//            dout_leaf_interface2bft    - 49-bit packet to the BFT
//            resend                     - BFT did not take the current dout
//            Input_1_V_V[_ap_vld/_ap_ack]  - outbound stream
//            Output_1_V_V[_ap_vld/_ap_ack] - inbound stream (FIFO head)
//            cfg_done                   - destination has been configured
//            rx_overflow                - sticky, data packet dropped
//            tx_pkt_cnt, rx_pkt_cnt, rx_drop_cnt - optional statistics
// Options  : define LEAF_BRIDGE_STATS_EN to add 16-bit saturating counters.
// Revision : 1.0 - initial release
// ============================================================================
module leaf_stream_bridge #(
  parameter int         RX_DEPTH = 16,
  parameter logic [2:0] MY_LEAF  = 3'd1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [48:0] din_leaf_bft2interface,
  output logic [48:0] dout_leaf_interface2bft,
  input  logic        resend,
  input  logic [31:0] Input_1_V_V,
  input  logic        Input_1_V_V_ap_vld,
  output logic        Input_1_V_V_ap_ack,
  output logic [31:0] Output_1_V_V,
  output logic        Output_1_V_V_ap_vld,
  input  logic        Output_1_V_V_ap_ack,
  output logic        cfg_done,
  output logic        rx_overflow
`ifdef LEAF_BRIDGE_STATS_EN
  ,
  output logic [15:0] tx_pkt_cnt,
  output logic [15:0] rx_pkt_cnt,
  output logic [15:0] rx_drop_cnt
`endif
);

  localparam int AW = $clog2(RX_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] C_FULL = CW'(RX_DEPTH);

  typedef enum logic [1:0] {
    ST_UNCFG = 2'd0,
    ST_IDLE  = 2'd1,
    ST_HOLD  = 2'd2
  } tx_state_t;

  // --------------------------------------------------------------------------
  // Input register: only the fields the bridge acts on are captured.
  // --------------------------------------------------------------------------
  logic        r_rx_vld;
  logic [3:0]  r_rx_port;
  logic [31:0] r_rx_payload;

  // Destination leaf, source leaf and reserved bits carry no meaning here.
  logic w_unused_din;
  assign w_unused_din = ^{din_leaf_bft2interface[47:45], din_leaf_bft2interface[40:32]};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_vld     <= 1'b0;
      r_rx_port    <= 4'd0;
      r_rx_payload <= 32'd0;
    end else begin
      r_rx_vld     <= din_leaf_bft2interface[48];
      r_rx_port    <= din_leaf_bft2interface[44:41];
      r_rx_payload <= din_leaf_bft2interface[31:0];
    end
  end

  logic w_cfg_in;
  logic w_data_in;
  assign w_cfg_in  = r_rx_vld && (r_rx_port == 4'd0);
  assign w_data_in = r_rx_vld && (r_rx_port == 4'd1);

  // --------------------------------------------------------------------------
  // Receive FIFO
  // --------------------------------------------------------------------------
  logic [31:0]   r_mem [RX_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_next;
  logic          r_out_vld;
  logic          r_overflow;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic          w_full;

  assign w_full = (r_count == C_FULL);
  assign w_pop  = r_out_vld && Output_1_V_V_ap_ack;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_push = w_data_in && (!w_full || w_pop);
  assign w_drop = w_data_in && w_full && !w_pop;

  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + 1'b1;
      2'b01:   w_count_next = r_count - 1'b1;
      default: w_count_next = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_out_vld  <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count    <= w_count_next;
      r_out_vld  <= (w_count_next != '0);
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  // Storage needs no reset; contents are only observed while occupancy > 0.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= r_rx_payload;
  end

  assign Output_1_V_V        = r_mem[r_rd_ptr];
  assign Output_1_V_V_ap_vld = r_out_vld;
  assign rx_overflow         = r_overflow;

  // --------------------------------------------------------------------------
  // Transmit FSM
  // --------------------------------------------------------------------------
  tx_state_t   r_state;
  tx_state_t   w_state_next;
  logic        w_ack;
  logic        w_load;
  logic        w_clear;
  logic [48:0] r_dout;
  logic [2:0]  r_dest_leaf;
  logic [3:0]  r_dest_port;
  logic        r_pend_vld;
  logic [2:0]  r_pend_leaf;
  logic [3:0]  r_pend_port;
  logic        r_cfg_done;
  logic        w_take_cfg;

  always_comb begin
    w_state_next = r_state;
    w_ack        = 1'b0;
    w_load       = 1'b0;
    w_clear      = 1'b0;
    case (r_state)
      ST_UNCFG: begin
        if (w_cfg_in) w_state_next = ST_IDLE;
      end
      ST_IDLE: begin
        w_ack = Input_1_V_V_ap_vld;
        if (Input_1_V_V_ap_vld) begin
          w_load       = 1'b1;
          w_state_next = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (!resend) begin
          if (Input_1_V_V_ap_vld) begin
            // Accepted packet is immediately replaced by the next word.
            w_ack  = 1'b1;
            w_load = 1'b1;
          end else begin
            w_clear      = 1'b1;
            w_state_next = ST_IDLE;
          end
        end
      end
      default: w_state_next = ST_UNCFG;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_UNCFG;
    else       r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_dout <= 49'd0;
    end else if (w_load) begin
      r_dout <= {1'b1, r_dest_leaf, r_dest_port, MY_LEAF, 6'd0, Input_1_V_V};
    end else if (w_clear) begin
      r_dout[48] <= 1'b0;
    end
  end

  // A destination change must not alter a packet that is still being
  // retried, so a config seen during HOLD is parked until HOLD is left.
  assign w_take_cfg = w_cfg_in && ((r_state != ST_HOLD) || w_clear);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_dest_leaf <= 3'd0;
      r_dest_port <= 4'd0;
      r_pend_vld  <= 1'b0;
      r_pend_leaf <= 3'd0;
      r_pend_port <= 4'd0;
      r_cfg_done  <= 1'b0;
    end else begin
      if (w_take_cfg) begin
        r_dest_leaf <= r_rx_payload[2:0];
        r_dest_port <= r_rx_payload[6:3];
        r_pend_vld  <= 1'b0;
      end else if (w_cfg_in) begin
        r_pend_leaf <= r_rx_payload[2:0];
        r_pend_port <= r_rx_payload[6:3];
        r_pend_vld  <= 1'b1;
      end else if (w_clear && r_pend_vld) begin
        r_dest_leaf <= r_pend_leaf;
        r_dest_port <= r_pend_port;
        r_pend_vld  <= 1'b0;
      end
      if (w_cfg_in) r_cfg_done <= 1'b1;
    end
  end

  assign dout_leaf_interface2bft = r_dout;
  assign Input_1_V_V_ap_ack      = w_ack;
  assign cfg_done                = r_cfg_done;

  // --------------------------------------------------------------------------
  // Optional statistics
  // --------------------------------------------------------------------------
`ifdef LEAF_BRIDGE_STATS_EN
  logic [15:0] r_tx_cnt;
  logic [15:0] r_rx_cnt;
  logic [15:0] r_drop_cnt;
  logic        w_tx_accept;

  assign w_tx_accept = (r_state == ST_HOLD) && !resend;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tx_cnt   <= 16'd0;
      r_rx_cnt   <= 16'd0;
      r_drop_cnt <= 16'd0;
    end else begin
      if (w_tx_accept && (r_tx_cnt != 16'hFFFF)) r_tx_cnt   <= r_tx_cnt + 16'd1;
      if (w_push      && (r_rx_cnt != 16'hFFFF)) r_rx_cnt   <= r_rx_cnt + 16'd1;
      if (w_drop      && (r_drop_cnt != 16'hFFFF)) r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  assign tx_pkt_cnt  = r_tx_cnt;
  assign rx_pkt_cnt  = r_rx_cnt;
  assign rx_drop_cnt = r_drop_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_leaf_stream_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_leaf_stream_bridge
// Purpose  : Self-checking bench for leaf_stream_bridge. Directed scenarios
//            followed by randomized traffic, all compared against a
//            transaction-level reference model (queue-based FIFO, packet
//            hold/accept rules, parked configuration).
// Revision : 1.0 - initial release
// ============================================================================
module tb_leaf_stream_bridge;

  localparam int         RX_DEPTH = 16;
  localparam logic [2:0] MY_LEAF  = 3'd1;

  logic        clk = 1'b0;
  logic        reset;
  logic [48:0] din;
  logic [48:0] dout;
  logic        resend;
  logic [31:0] in_data;
  logic        in_vld;
  logic        in_ack;
  logic [31:0] out_data;
  logic        out_vld;
  logic        out_ack;
  logic        cfg_done;
  logic        rx_overflow;
`ifdef LEAF_BRIDGE_STATS_EN
  logic [15:0] tx_pkt_cnt, rx_pkt_cnt, rx_drop_cnt;
`endif

  always #5 clk = ~clk;

  leaf_stream_bridge #(.RX_DEPTH(RX_DEPTH), .MY_LEAF(MY_LEAF)) u_dut (
    .clk                     (clk),
    .reset                   (reset),
    .din_leaf_bft2interface  (din),
    .dout_leaf_interface2bft (dout),
    .resend                  (resend),
    .Input_1_V_V             (in_data),
    .Input_1_V_V_ap_vld      (in_vld),
    .Input_1_V_V_ap_ack      (in_ack),
    .Output_1_V_V            (out_data),
    .Output_1_V_V_ap_vld     (out_vld),
    .Output_1_V_V_ap_ack     (out_ack),
    .cfg_done                (cfg_done),
    .rx_overflow             (rx_overflow)
`ifdef LEAF_BRIDGE_STATS_EN
    ,
    .tx_pkt_cnt              (tx_pkt_cnt),
    .rx_pkt_cnt              (rx_pkt_cnt),
    .rx_drop_cnt             (rx_drop_cnt)
`endif
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit          m_cfg;
  bit [2:0]    m_dl;
  bit [3:0]    m_dp;
  bit          m_pv;
  bit [2:0]    m_pl;
  bit [3:0]    m_pp;
  bit          m_hold;
  logic [48:0] m_dout;
  bit          m_ovf;
  logic [31:0] m_q[$];
  logic [48:0] m_din_d;   // BFT packet as seen by the bridge one cycle later

  function automatic logic [48:0] mk(input logic [3:0] port, input logic [31:0] pl);
    return {1'b1, MY_LEAF, port, 3'd5, 6'd0, pl};
  endfunction

  task automatic model_reset();
    m_cfg = 0; m_dl = 0; m_dp = 0; m_pv = 0; m_pl = 0; m_pp = 0;
    m_hold = 0; m_dout = '0; m_ovf = 0; m_q.delete(); m_din_d = '0;
  endtask

  // One clock cycle: inputs are already driven (after a negedge).
  task automatic step();
    logic        exp_ack;
    bit          was_hold, leave, pop, is_cfg, is_data;
    logic [48:0] newpkt;
    #1;
    if (!m_cfg)       exp_ack = 1'b0;
    else if (!m_hold) exp_ack = in_vld;
    else              exp_ack = !resend && in_vld;
    chk("in_ack", {63'd0, in_ack}, {63'd0, exp_ack});
    chk("out_vld", {63'd0, out_vld}, {63'd0, m_q.size() != 0});
    if (m_q.size() != 0) chk("out_data", {32'd0, out_data}, {32'd0, m_q[0]});
    @(posedge clk);
    if (reset) begin
      model_reset();
    end else begin
      was_hold = m_hold;
      leave    = 0;
      newpkt   = {1'b1, m_dl, m_dp, MY_LEAF, 6'd0, in_data};
      pop      = (m_q.size() != 0) && out_ack;
      if (m_cfg) begin
        if (!was_hold) begin
          if (in_vld) begin m_dout = newpkt; m_hold = 1; end
        end else if (!resend) begin
          if (in_vld) m_dout = newpkt;
          else begin m_dout[48] = 1'b0; m_hold = 0; leave = 1; end
        end
      end
      is_cfg  = m_din_d[48] && (m_din_d[44:41] == 4'd0);
      is_data = m_din_d[48] && (m_din_d[44:41] == 4'd1);
      if (is_cfg) begin
        if (!was_hold || leave) begin
          m_dl = m_din_d[2:0]; m_dp = m_din_d[6:3]; m_pv = 0;
        end else begin
          m_pl = m_din_d[2:0]; m_pp = m_din_d[6:3]; m_pv = 1;
        end
        m_cfg = 1;
      end else if (leave && m_pv) begin
        m_dl = m_pl; m_dp = m_pp; m_pv = 0;
      end
      if (pop) void'(m_q.pop_front());
      if (is_data) begin
        if (m_q.size() == RX_DEPTH) m_ovf = 1;
        else m_q.push_back(m_din_d[31:0]);
      end
      m_din_d = din;
    end
    #1;
    chk("dout", {15'd0, dout}, {15'd0, m_dout});
    chk("cfg_done", {63'd0, cfg_done}, {63'd0, m_cfg});
    chk("rx_overflow", {63'd0, rx_overflow}, {63'd0, m_ovf});
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1; step(); reset = 0;
  endtask

  task automatic send_cfg(input logic [31:0] pl);
    din = mk(4'd0, pl); step(); din = '0; step();
  endtask

  initial begin
    reset = 1; din = '0; resend = 0; in_data = '0; in_vld = 0; out_ack = 0;
    repeat (2) @(posedge clk);
    model_reset();
    @(negedge clk);
    chk("rst_dout", {15'd0, dout}, 64'd0);
    chk("rst_cfg_done", {63'd0, cfg_done}, 64'd0);
    chk("rst_ovf", {63'd0, rx_overflow}, 64'd0);
    chk("rst_out_vld", {63'd0, out_vld}, 64'd0);
    chk("rst_in_ack", {63'd0, in_ack}, 64'd0);
    reset = 0;

    // Unconfigured: stream word must not be taken.
    in_vld = 1; in_data = 32'hDEADBEEF;
    repeat (20) step();
    chk("uncfg_cfg_done", {63'd0, cfg_done}, 64'd0);

    // Configure destination leaf 3 / port 5, then send one word.
    in_vld = 0;
    send_cfg(32'h0000002B);
    chk("cfg_done_set", {63'd0, cfg_done}, 64'd1);
    in_vld = 1; in_data = 32'h12345678;
    step();
    in_vld = 0;
    chk("tx_pkt", {15'd0, dout},
        {15'd0, 1'b1, 3'd3, 4'd5, MY_LEAF, 6'd0, 32'h12345678});
    step();

    // Resend backpressure for 3 cycles, then release.
    in_vld = 1; in_data = 32'hA1A1A1A1; step();
    resend = 1; in_data = 32'hA2A2A2A2;
    repeat (3) step();
    chk("resend_hold", {32'd0, dout[31:0]}, 64'hA1A1A1A1);
    resend = 0; step();
    chk("resend_next", {32'd0, dout[31:0]}, 64'hA2A2A2A2);
    in_vld = 0; step();

    // Overflow: 17 data packets with no consumer.
    for (int i = 0; i < 17; i++) begin din = mk(4'd1, 32'(i)); step(); end
    din = '0; step(); step();
    chk("ovf_set", {63'd0, rx_overflow}, 64'd1);
    out_ack = 1;
    for (int i = 0; i < 16; i++) begin
      chk("drain", {32'd0, out_data}, 64'(i));
      step();
    end
    chk("drain_empty", {63'd0, out_vld}, 64'd0);
    out_ack = 0;

    // Full FIFO with simultaneous push and pop.
    do_reset();
    for (int i = 0; i < 16; i++) begin din = mk(4'd1, 32'(100 + i)); step(); end
    din = mk(4'd1, 32'h777); step();
    din = '0; out_ack = 1; step();   // registered push coincides with pop
    out_ack = 0; step();
    chk("fullpp_no_drop", {63'd0, rx_overflow}, 64'd0);
    out_ack = 1;
    for (int i = 0; i < 16; i++) step();
    chk("fullpp_count16", {63'd0, out_vld}, 64'd0);
    out_ack = 0;

    // Reset while holding a packet under resend.
    send_cfg(32'h0000002B);
    in_vld = 1; in_data = 32'hCAFEF00D; step();
    resend = 1; step();
    reset = 1; step(); reset = 0;
    chk("rst_hold_dout", {15'd0, dout}, 64'd0);
    chk("rst_hold_cfg", {63'd0, cfg_done}, 64'd0);
    step();
    chk("rst_hold_uncfg_ack", {63'd0, in_ack}, 64'd0);
    resend = 0; in_vld = 0;

    // Randomized traffic.
    send_cfg(32'h0000001A);
    for (int n = 0; n < 3000; n++) begin
      reset   = ($urandom_range(0, 999) < 2);
      if ($urandom_range(0, 1) == 1)
        din = {1'b1, 3'($urandom), 4'($urandom_range(0, 3)), 3'($urandom), 6'($urandom), 32'($urandom)};
      else
        din = '0;
      resend  = ($urandom_range(0, 9) < 3);
      in_vld  = ($urandom_range(0, 9) < 6);
      in_data = $urandom;
      out_ack = ((n / 200) % 2 == 1) ? ($urandom_range(0, 9) < 2) : ($urandom_range(0, 1) == 1);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
